// File: rtl/shift_seq_arbiter.sv
// Two-requester round-robin front end for a single shift-left-by-one datapath.
// Variable shifts of 0..N-1 are performed iteratively, one bit per clock.
module shift_seq_arbiter #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [SW-1:0] req0_amt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [SW-1:0] req1_amt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [N-1:0]  res_b,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    logic          ptr_q, ptr_d;
    logic [N-1:0]  res_b_q, res_b_d;
    logic          res_id_q, res_id_d;

    logic [1:0]    valid_vec;
    logic [1:0]    ready_vec;
    logic          gnt_any;
    logic          gnt_id;
    logic [N-1:0]  sel_a;
    logic [SW-1:0] sel_amt;
    logic [N-1:0]  acc_shl;

    assign valid_vec = {req1_valid, req0_valid};
    assign gnt_any   = |valid_vec;
    // On contention the pointer decides; otherwise the sole valid requester wins.
    assign gnt_id    = (&valid_vec) ? ptr_q : req1_valid;
    assign sel_a     = gnt_id ? req1_a : req0_a;
    assign sel_amt   = gnt_id ? req1_amt : req0_amt;
    assign acc_shl   = {acc_q[N-2:0], 1'b0};

    // READY is gated by rst_n so it drops asynchronously while reset is held.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = rst_n && (state_q == IDLE) && valid_vec[gi]
                               && (gnt_id == 1'(gi));
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign res_b      = res_b_q;
    assign res_id     = res_id_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        res_b_d  = res_b_q;
        res_id_d = res_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    acc_d = sel_a;
                    cnt_d = sel_amt;
                    id_d  = gnt_id;
                    ptr_d = ~gnt_id;
                    if (sel_amt == '0) begin
                        state_d  = HOLD;
                        res_b_d  = sel_a;
                        res_id_d = gnt_id;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - SW'(1);
                // Result register is loaded on the way into HOLD so it stays put afterwards.
                if (cnt_q == SW'(1)) begin
                    state_d  = HOLD;
                    res_b_d  = acc_shl;
                    res_id_d = id_q;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            ptr_q    <= 1'b0;
            res_b_q  <= '0;
            res_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            res_b_q  <= res_b_d;
            res_id_q <= res_id_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Directed bench for shift_seq_arbiter: reset, latency, overflow, round-robin, backpressure.
module tb_shift_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req1_a = '0;
    logic [4:0]  req0_amt = '0, req1_amt = '0;
    logic        res_valid, res_ready = 1'b0, res_id, busy;
    logic [31:0] res_b;

    int checks = 0;
    int failures = 0;

    shift_seq_arbiter #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_amt(req1_amt),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_b(res_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Present a request at a falling edge, confirm READY, let the rising edge accept it.
    task automatic accept(input string tag, input bit who, input logic [31:0] a, input logic [4:0] amt);
        @(negedge clk);
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_amt = amt;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_amt = amt;
        end
        #1;
        check_eq({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge until RES_VALID is seen; bounded.
    task automatic wait_result(output int edges);
        edges = 0;
        @(negedge clk);
        while (!res_valid && edges < 64) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic take_result;
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int e;
    int seen;
    int got_id[4];
    int got_b[4];

    initial begin
        // Reset state, with a requester asserting VALID during reset.
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check_eq("rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_res_b", res_b, 32'd0);
        check_eq("rst_res_id", {31'd0, res_id}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-SHIFT abandons the operation.
        accept("t1", 1'b0, 32'd5, 5'd10);
        repeat (2) @(negedge clk);
        check_eq("t1_busy_pre", {31'd0, busy}, 32'd1);
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("t1_busy_async", {31'd0, busy}, 32'd0);
        check_eq("t1_valid_async", {31'd0, res_valid}, 32'd0);
        check_eq("t1_ready_async", {30'd0, req1_ready, req0_ready}, 32'd0);
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check_eq("t1_no_result", seen, 32'd0);

        // AMT=0 goes straight to HOLD.
        accept("t2", 1'b0, 32'd45, 5'd0);
        wait_result(e);
        check_eq("t2_latency", e, 32'd0);
        check_eq("t2_res_b", res_b, 32'd45);
        check_eq("t2_res_id", {31'd0, res_id}, 32'd0);
        take_result();

        // Requester 1, three shift cycles.
        accept("t3", 1'b1, 32'd290, 5'd3);
        wait_result(e);
        check_eq("t3_latency", e, 32'd3);
        check_eq("t3_res_b", res_b, 32'd2320);
        check_eq("t3_res_id", {31'd0, res_id}, 32'd1);
        take_result();
        @(negedge clk);
        check_eq("t3_idle", {31'd0, busy}, 32'd0);
        check_eq("t3_b_held", res_b, 32'd2320);

        // Maximum shift: MSBs discarded, zero fill.
        accept("t4", 1'b0, 32'h8000_0001, 5'd31);
        wait_result(e);
        check_eq("t4_latency", e, 32'd31);
        check_eq("t4_res_b", res_b, 32'h8000_0000);
        take_result();

        // Both requesters valid continuously: strict alternation from ptr=0.
        pulse_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1; req0_amt = 5'd1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_amt = 5'd2;
        res_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && seen < 4; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got_id[seen] = int'(res_id);
                got_b[seen]  = int'(res_b);
                seen++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("t5_count", seen, 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t5_id%0d", k), got_id[k], 32'(k % 2));
            check_eq($sformatf("t5_b%0d", k), got_b[k], (k % 2) ? 32'd4 : 32'd2);
        end
        repeat (5) @(negedge clk);
        res_ready = 1'b0;
        check_eq("t5_drained", {31'd0, busy}, 32'd0);

        // Backpressure in HOLD: result stable, no READY; accept resumes after release.
        accept("t6", 1'b0, 32'd7, 5'd2);
        wait_result(e);
        check_eq("t6_latency", e, 32'd2);
        req1_valid = 1'b1; req1_a = 32'd3; req1_amt = 5'd1;
        seen = 0;
        repeat (5) begin
            #1;
            if (!res_valid || res_b !== 32'd28 || req1_ready || req0_ready) seen++;
            @(negedge clk);
        end
        check_eq("t6_hold_stable", seen, 32'd0);
        check_eq("t6_res_b", res_b, 32'd28);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t6_ready_after", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_result(e);
        check_eq("t6_next_latency", e, 32'd1);
        check_eq("t6_next_b", res_b, 32'd6);
        check_eq("t6_next_id", {31'd0, res_id}, 32'd1);
        take_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
